// File: rtl/core_mdu_pkg.sv
// core_mdu_pkg: shared types and parameter checks
// for the iterative multiply/divide unit.
package core_mdu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } mdu_state_e;

  typedef enum logic [2:0] {
    OP_MUL,
    OP_MULH,
    OP_MULHU,
    OP_MULHSU,
    OP_DIV,
    OP_DIVU,
    OP_REM,
    OP_REMU
  } mdu_op_e;

  function automatic bit xlen_ok(int x);
    return (x == 32) || (x == 64);
  endfunction

  function automatic bit mul_unroll_ok(int u);
    return (u == 1) || (u == 2) || (u == 4) || (u == 8);
  endfunction

  function automatic bit div_unroll_ok(int u);
    return (u == 1) || (u == 2);
  endfunction

endpackage

// File: rtl/core_pipe_exec_mdu_iter_if.sv
// core_pipe_exec_mdu_iter_if: request/response bundle
// between the execute stage and the MDU.
interface core_pipe_exec_mdu_iter_if #(
  parameter int XLEN = 64
);
  logic            flush;
  logic            valid;
  logic            op_word;
  logic            op_mul;
  logic            op_mulh;
  logic            op_mulhu;
  logic            op_mulhsu;
  logic            op_div;
  logic            op_divu;
  logic            op_rem;
  logic            op_remu;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            ready;
  logic [XLEN-1:0] rd;

  modport master (
    output flush, valid, op_word,
    output op_mul, op_mulh, op_mulhu, op_mulhsu,
    output op_div, op_divu, op_rem, op_remu,
    output rs1, rs2,
    input  ready, rd
  );

  modport slave (
    input  flush, valid, op_word,
    input  op_mul, op_mulh, op_mulhu, op_mulhsu,
    input  op_div, op_divu, op_rem, op_remu,
    input  rs1, rs2,
    output ready, rd
  );
endinterface

// File: rtl/core_mdu_div_step.sv
// core_mdu_div_step: one combinational restoring-divide
// step on unsigned magnitudes.
module core_mdu_div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem,
  input  logic            shift_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic            q_bit
);
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  // rem < divisor, so the difference fits XLEN+1 signed
  assign rem_sh   = {rem, shift_bit};
  assign diff     = rem_sh - {1'b0, divisor};
  assign q_bit    = ~diff[XLEN];
  assign rem_next = q_bit ? diff[XLEN-1:0]
                          : rem_sh[XLEN-1:0];
endmodule

// File: rtl/core_pipe_exec_mdu_iter.sv
// core_pipe_exec_mdu_iter: iterative RV64M multiply/divide.
// One accumulator serves shift-add multiply and restoring divide.
module core_pipe_exec_mdu_iter
  import core_mdu_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int MUL_UNROLL = 4,
  parameter int DIV_UNROLL = 1
) (
  input logic g_clk,
  input logic g_resetn,
  core_pipe_exec_mdu_iter_if.slave mdu
);
  localparam int CW    = $clog2(XLEN) + 1;
  localparam bit HAS_W = XLEN > 32;

  if (!xlen_ok(XLEN)) begin : g_bad_xlen
    $error("XLEN must be 32 or 64");
  end
  if (!mul_unroll_ok(MUL_UNROLL)) begin : g_bad_mul
    $error("MUL_UNROLL must be 1, 2, 4 or 8");
  end
  if (!div_unroll_ok(DIV_UNROLL)) begin : g_bad_div
    $error("DIV_UNROLL must be 1 or 2");
  end

  mdu_state_e      state_q, state_d;
  mdu_op_e         op_q, op_d;
  logic            word_q, s1_q, s2_q;
  logic            a_neg_q, b_neg_q;
  logic [CW-1:0]   cnt_q, n_q, n_d;
  logic [XLEN-1:0] a_q, b_q, acc_lo_q;
  logic [XLEN:0]   acc_hi_q;
  logic [XLEN-1:0] rd_q, rd_d;
  logic            ready_q, rd_we;

  logic            word_d, s1, s2, neg1, neg2;
  logic            is_div, is_rem, div0, ovf, start;
  logic [XLEN-1:0] x1, x2, sx1, mag1, mag2, mn;
  logic [XLEN-1:0] spec_res;

  always_comb begin
    op_d = OP_MUL;
    unique case (1'b1)
      mdu.op_mul:    op_d = OP_MUL;
      mdu.op_mulh:   op_d = OP_MULH;
      mdu.op_mulhu:  op_d = OP_MULHU;
      mdu.op_mulhsu: op_d = OP_MULHSU;
      mdu.op_div:    op_d = OP_DIV;
      mdu.op_divu:   op_d = OP_DIVU;
      mdu.op_rem:    op_d = OP_REM;
      mdu.op_remu:   op_d = OP_REMU;
      default:       op_d = OP_MUL;
    endcase
  end

  always_comb begin
    word_d = HAS_W & mdu.op_word;
    s1 = op_d inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    s2 = op_d inside {OP_MULH, OP_DIV, OP_REM};
    is_div = op_d inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    is_rem = op_d inside {OP_REM, OP_REMU};
    x1  = mdu.rs1;
    x2  = mdu.rs2;
    sx1 = mdu.rs1;
    mn  = {1'b1, {(XLEN-1){1'b0}}};
    n_d = CW'(XLEN);
    if (word_d) begin
      x1  = s1 ? XLEN'($signed(mdu.rs1[31:0]))
               : XLEN'(mdu.rs1[31:0]);
      x2  = s2 ? XLEN'($signed(mdu.rs2[31:0]))
               : XLEN'(mdu.rs2[31:0]);
      sx1 = XLEN'($signed(mdu.rs1[31:0]));
      mn  = ~XLEN'(32'h7fff_ffff);
      n_d = CW'(32);
    end
    neg1 = s1 & x1[XLEN-1];
    neg2 = s2 & x2[XLEN-1];
    mag1 = neg1 ? -x1 : x1;
    mag2 = neg2 ? -x2 : x2;
    div0 = is_div && (x2 == '0);
    ovf  = is_div && s1 && (x1 == mn) && (&x2);
    spec_res = div0 ? (is_rem ? sx1 : '1)
                    : (is_rem ? '0 : x1);
  end

  assign start = (state_q == ST_IDLE) && mdu.valid
              && !mdu.flush;

  // shift-add step; signed rs2 subtracts on its top bit
  logic [XLEN:0]   hi_n;
  logic [XLEN-1:0] lo_n, mul_res;
  logic [XLEN+1:0] sum, addend;
  logic [CW-1:0]   pos;
  logic            mul_last;

  always_comb begin
    hi_n   = acc_hi_q;
    lo_n   = acc_lo_q;
    sum    = '0;
    addend = '0;
    pos    = '0;
    for (int j = 0; j < MUL_UNROLL; j++) begin
      pos    = cnt_q + CW'(j);
      addend = lo_n[0] ? {{2{a_q[XLEN-1] & s1_q}}, a_q} : '0;
      if (s2_q && (pos == n_q - CW'(1)))
        sum = {hi_n[XLEN], hi_n} - addend;
      else
        sum = {hi_n[XLEN], hi_n} + addend;
      hi_n = sum[XLEN+1:1];
      lo_n = {sum[0], lo_n[XLEN-1:1]};
    end
    mul_last = (cnt_q + CW'(MUL_UNROLL)) == n_q;
    mul_res  = (op_q == OP_MUL) ? lo_n : hi_n[XLEN-1:0];
    if (word_q) mul_res = XLEN'($signed(lo_n[XLEN-1 -: 32]));
  end

  logic [XLEN-1:0] drem [DIV_UNROLL+1];
  logic [XLEN-1:0] dquo [DIV_UNROLL+1];
  logic            div_last;

  assign drem[0]  = acc_hi_q[XLEN-1:0];
  assign dquo[0]  = acc_lo_q;
  assign div_last = (cnt_q + CW'(DIV_UNROLL)) == n_q;

  for (genvar g = 0; g < DIV_UNROLL; g++) begin : g_div
    logic qb;
    core_mdu_div_step #(.XLEN(XLEN)) u_step (
      .rem       (drem[g]),
      .shift_bit (dquo[g][XLEN-1]),
      .divisor   (b_q),
      .rem_next  (drem[g+1]),
      .q_bit     (qb)
    );
    assign dquo[g+1] = {dquo[g][XLEN-2:0], qb};
  end

  logic [XLEN-1:0] fix_q, fix_r, fix_res;

  always_comb begin
    fix_q = (a_neg_q ^ b_neg_q) ? -acc_lo_q : acc_lo_q;
    fix_r = a_neg_q ? -acc_hi_q[XLEN-1:0]
                    : acc_hi_q[XLEN-1:0];
    fix_res = (op_q inside {OP_REM, OP_REMU}) ? fix_r : fix_q;
    if (word_q) fix_res = XLEN'($signed(fix_res[31:0]));
  end

  always_comb begin
    state_d = state_q;
    rd_we   = 1'b0;
    rd_d    = rd_q;
    unique case (state_q)
      ST_IDLE: if (start) begin
        if (div0 || ovf) begin
          state_d = ST_DONE;
          rd_we   = 1'b1;
          rd_d    = spec_res;
        end else begin
          state_d = is_div ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL: if (mul_last) begin
        state_d = ST_DONE;
        rd_we   = 1'b1;
        rd_d    = mul_res;
      end
      ST_DIV: if (div_last) state_d = ST_FIX;
      ST_FIX: begin
        state_d = ST_DONE;
        rd_we   = 1'b1;
        rd_d    = fix_res;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (mdu.flush) begin
      state_d = ST_IDLE;
      rd_we   = 1'b0;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= rd_we;
      if (rd_we) rd_q <= rd_d;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      op_q     <= OP_MUL;
      word_q   <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      cnt_q    <= '0;
      n_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
    end else if (start) begin
      op_q     <= op_d;
      word_q   <= word_d;
      s1_q     <= s1;
      s2_q     <= s2;
      a_neg_q  <= neg1;
      b_neg_q  <= neg2;
      cnt_q    <= '0;
      n_q      <= n_d;
      a_q      <= x1;
      b_q      <= is_div ? mag2 : x2;
      acc_hi_q <= '0;
      // word dividends sit in the top half so the msb-first walk starts at bit 31
      acc_lo_q <= is_div ? (mag1 << (CW'(XLEN) - n_d)) : x2;
    end else if (state_q == ST_MUL) begin
      acc_hi_q <= hi_n;
      acc_lo_q <= lo_n;
      cnt_q    <= cnt_q + CW'(MUL_UNROLL);
    end else if (state_q == ST_DIV) begin
      acc_hi_q <= {1'b0, drem[DIV_UNROLL]};
      acc_lo_q <= dquo[DIV_UNROLL];
      cnt_q    <= cnt_q + CW'(DIV_UNROLL);
    end
  end

  assign mdu.ready = ready_q;
  assign mdu.rd    = rd_q;

endmodule

// File: doc/core_pipe_exec_mdu_iter.md
# core_pipe_exec_mdu_iter

Parametrised iterative multiply/divide unit for the execute stage. Replaces the multiply-only MDU with one datapath for all eight RV64M operations plus their word forms. Multiplier and divider throughput are set independently by unroll parameters. It accepts one operation at a time under a valid/ready handshake, is cancelled by `flush`, and returns a registered, sign-corrected result.

## Interface

Parameters:
- `XLEN`, default 64: operand width; legal values 32 and 64. With `XLEN`=32, `op_word` is ignored.
- `MUL_UNROLL`, default 4: multiplier bits retired per cycle; legal values 1, 2, 4, 8.
- `DIV_UNROLL`, default 1: quotient bits retired per cycle; legal values 1, 2.

Ports:
- `g_clk` in 1: clock. One clock domain only.
- `g_resetn` in 1: reset. Asynchronous, active-low.
- `flush` in 1: abandon the current operation.
- `valid` in 1: operation request. Held stable until `ready` or `flush`.
- `op_word` in 1: 32-bit word operation (the *W forms).
- `op_mul`, `op_mulh`, `op_mulhu`, `op_mulhsu` in 1 each: one-hot multiply selects.
- `op_div`, `op_divu`, `op_rem`, `op_remu` in 1 each: one-hot divide selects.
- `rs1`, `rs2` in `XLEN`: source operands.
- `ready` out 1: one-cycle pulse; `rd` is valid in this cycle.
- `rd` out `XLEN`: result register. Holds its value until the next start.

## Operation

- FSM states: IDLE, MUL, DIV, FIX, DONE. Reset state is IDLE; `ready`=0 and `rd`=0 at reset.
- Start: in IDLE with `valid`=1 and `flush`=0, latch operands, latch the op, and load the iteration counter.
  - Word ops: take the low 32 bits of each operand, sign- or zero-extended per op signedness.
  - N = 32 for word ops, otherwise N = `XLEN`.
- MUL: shift-add over a 2·`XLEN` accumulator.
  - Each cycle retires `MUL_UNROLL` bits of rs2.
  - Signed rs1 (mulh, mulhsu) sign-extends the partial sums.
  - Signed rs2 (mulh) subtracts on the final bit.
  - After N/`MUL_UNROLL` cycles, go to DONE.
  - Result selection:
    - mul: low `XLEN` bits.
    - mulh/mulhu/mulhsu: high `XLEN` bits.
    - mulw: bits 31:0 sign-extended.
- DIV: restoring divide on operand magnitudes.
  - Each cycle retires `DIV_UNROLL` quotient bits.
  - After N/`DIV_UNROLL` cycles, go to FIX.
- FIX: apply signs, then go to DONE.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of rs1.
  - Word results are sign-extended from bit 31.
- Special cases resolve at start and go directly to DONE with no iteration:
  - Divide by zero: quotient is all ones; remainder is the dividend (word ops sign-extended).
  - Signed overflow (most-negative ÷ −1): quotient is the dividend; remainder is 0.
- DONE: `rd` is written on entry, `ready`=1 for this single cycle, then return to IDLE.
- Back-to-back: if `valid` is still high in the IDLE cycle after DONE, a new operation starts. The pipeline must lower or replace `valid` by that cycle.
- `flush` in any state: go to IDLE at the next edge.
  - `ready` never asserts for the flushed op.
  - `rd` is unchanged.
  - `flush` together with `valid` in IDLE: no start.
- Op-select bits are sampled only at start; changes mid-operation are ignored.
- Asynchronous reset mid-operation: immediately go to IDLE, `ready`=0, `rd`=0.

## Timing

- Latency is counted from the start edge to the cycle in which `ready` is high:
  - Multiply: N/`MUL_UNROLL` + 1 cycles (64-bit, unroll 4: 17).
  - Divide: N/`DIV_UNROLL` + 2 cycles (64-bit, unroll 1: 66; word: 34).
  - Special-case divide: 1 cycle.
- `ready` and `rd` are driven directly from flops; there is no combinational path from the inputs.
- The minimum gap between two starts is latency + 1 cycles.

## Structure

- Package `core_mdu_pkg` contains:
  - FSM state enum.
  - Op-class encoding: MUL, MULH, MULHU, MULHSU, DIV, DIVU, REM, REMU.
  - Unroll legality checks as elaboration-time asserts.
- Sub-module `core_mdu_div_step`: combinational restoring-divide step, instantiated `DIV_UNROLL` times.
  - Inputs: partial remainder, dividend shift bit, divisor.
  - Outputs: next remainder, quotient bit.
- The multiplier step loop stays inline.

## Test plan

- mulh, rs1=0x8000000000000000, rs2=−1, unroll 4 → `ready` at cycle 17, `rd`=0x0000000000000000; the same operands with mul → `rd`=0x8000000000000000.
- divw, rs1=0x00000000FFFFFFF9 (−7), rs2=2 → `ready` at cycle 34, `rd`=0xFFFFFFFFFFFFFFFD; remw with the same operands → `rd`=0xFFFFFFFFFFFFFFFF.
- Divide by zero: div rs1=5, rs2=0 → `ready` after 1 cycle, `rd`=0xFFFFFFFFFFFFFFFF; remu with the same operands → `rd`=5.
- Overflow: div rs1=0x8000000000000000, rs2=−1 → `rd`=0x8000000000000000 after 1 cycle; rem → `rd`=0.
- `flush` pulsed at cycle 10 of a divu → `ready` never asserts and `rd` keeps its prior value; next divu 100/7 → `rd`=14 at cycle 66.
- Asynchronous reset asserted mid-mul, then released → `ready`=0 and `rd`=0 immediately; a following mulhsu with rs1=−1, rs2=2 → `rd`=0xFFFFFFFFFFFFFFFF.
